// File: rtl/req_rsp_chk_pkg.sv
// req_rsp_chk_pkg: shared types and parameter defaults for the request/response
// latency checker.
//   chan_state_e : per-channel FSM state (IDLE / WAIT)
//   err_evt_t    : one-cycle error event bundle {early, tmo, proto}
//   DEF_*        : default values for NUM_CH, CNT_W, ERR_CNT_W
package req_rsp_chk_pkg;

  localparam int unsigned DEF_NUM_CH    = 4;
  localparam int unsigned DEF_CNT_W     = 8;
  localparam int unsigned DEF_ERR_CNT_W = 16;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } chan_state_e;

  typedef struct packed {
    logic early;
    logic tmo;
    logic proto;
  } err_evt_t;

endpackage

// File: rtl/req_rsp_chan.sv
// req_rsp_chan: single-channel request/response latency checker.
// Tracks one outstanding request, counts its latency and judges the response
// against the window captured at the request rise.
// Optional macro REQ_RSP_CHK_STAT_EN adds o_pass / o_lat for latency stats.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   i_run                 checking active (enable and valid config)
//   i_cfg_min, i_cfg_max  latency window, captured on request rise
//   i_req, i_rsp          request level, response pulse
//   o_busy                request outstanding (state WAIT)
//   o_evt                 error events judged at this edge (combinational)
//   o_pass, o_lat         (stat build) passing response and its latency
module req_rsp_chan
  import req_rsp_chk_pkg::*;
#(
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_run,
  input  logic [CNT_W-1:0] i_cfg_min,
  input  logic [CNT_W-1:0] i_cfg_max,
  input  logic             i_req,
  input  logic             i_rsp,
  output logic             o_busy,
  output err_evt_t         o_evt
`ifdef REQ_RSP_CHK_STAT_EN
  ,
  output logic             o_pass,
  output logic [CNT_W-1:0] o_lat
`endif
);

  chan_state_e      r_state, w_state_nxt;
  logic [CNT_W-1:0] r_lat, w_lat_nxt;
  logic [CNT_W-1:0] r_min, w_min_nxt;
  logic [CNT_W-1:0] r_max, w_max_nxt;
  logic             r_req_d;
  logic             w_rise;

  assign w_rise = i_req & ~r_req_d;
  assign o_busy = (r_state == ST_WAIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_lat   <= '0;
      r_min   <= '0;
      r_max   <= '0;
      r_req_d <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_lat   <= w_lat_nxt;
      r_min   <= w_min_nxt;
      r_max   <= w_max_nxt;
      r_req_d <= i_req;
    end
  end

  // r_lat holds the latency that the coming edge represents: it is 1 right
  // after the rise edge (which itself is L=0) and stays 0 while IDLE.
  always_comb begin
    w_state_nxt = r_state;
    w_lat_nxt   = r_lat;
    w_min_nxt   = r_min;
    w_max_nxt   = r_max;
    o_evt       = '0;
    if (!i_run) begin
      w_state_nxt = ST_IDLE;
      w_lat_nxt   = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_lat_nxt = '0;
          if (w_rise) begin
            w_min_nxt = i_cfg_min;
            w_max_nxt = i_cfg_max;
            if (i_rsp) begin
              // Response in the rise cycle is judged as L=0 right here.
              o_evt.early = (i_cfg_min != '0);
            end else begin
              w_state_nxt = ST_WAIT;
              w_lat_nxt   = CNT_W'(1);
            end
          end else if (i_rsp) begin
            o_evt.proto = 1'b1;
          end
        end
        ST_WAIT: begin
          if (w_rise) o_evt.proto = 1'b1;
          // With r_max all-ones this can never hold, so timeout is disabled.
          if (r_lat > r_max) begin
            o_evt.tmo   = 1'b1;
            w_state_nxt = ST_IDLE;
            w_lat_nxt   = '0;
          end else if (i_rsp) begin
            o_evt.early = (r_lat < r_min);
            w_state_nxt = ST_IDLE;
            w_lat_nxt   = '0;
          end else if (r_lat != '1) begin
            w_lat_nxt = r_lat + CNT_W'(1);
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_lat_nxt   = '0;
        end
      endcase
    end
  end

`ifdef REQ_RSP_CHK_STAT_EN
  // r_lat is zero in IDLE, so it also reports L=0 for a rise-cycle response.
  assign o_pass = i_run & i_rsp & (w_rise | (r_state == ST_WAIT)) &
                  ~o_evt.early & ~o_evt.tmo;
  assign o_lat  = r_lat;
`endif

endmodule

// File: rtl/req_rsp_checker.sv
// req_rsp_checker: multi-channel request/response latency checker.
// NUM_CH independent req_rsp_chan instances; this level holds the sticky
// error flags, the saturating error counter, cfg_err and irq.
// Optional macro REQ_RSP_CHK_STAT_EN adds max_lat (per-channel maximum
// passing latency, cleared by reset and err_clr).
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   enable                     checking enable
//   cfg_min_dly, cfg_max_dly   inclusive response latency window
//   req, rsp                   per-channel request level / response pulse
//   err_clr                    clear sticky flags and err_cnt
//   busy                       per-channel outstanding request
//   err_early/err_tmo/err_proto sticky per-channel error flags
//   err_cnt                    saturating total error count
//   cfg_err                    registered cfg_min_dly > cfg_max_dly
//   irq                        registered OR of all sticky flags
//   max_lat                    (stat build) NUM_CH x CNT_W max passing latency
module req_rsp_checker
  import req_rsp_chk_pkg::*;
#(
  parameter int unsigned NUM_CH    = DEF_NUM_CH,
  parameter int unsigned CNT_W     = DEF_CNT_W,
  parameter int unsigned ERR_CNT_W = DEF_ERR_CNT_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic [CNT_W-1:0]     cfg_min_dly,
  input  logic [CNT_W-1:0]     cfg_max_dly,
  input  logic [NUM_CH-1:0]    req,
  input  logic [NUM_CH-1:0]    rsp,
  input  logic                 err_clr,
  output logic [NUM_CH-1:0]    busy,
  output logic [NUM_CH-1:0]    err_early,
  output logic [NUM_CH-1:0]    err_tmo,
  output logic [NUM_CH-1:0]    err_proto,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic                 cfg_err,
  output logic                 irq
`ifdef REQ_RSP_CHK_STAT_EN
  ,
  output logic [NUM_CH*CNT_W-1:0] max_lat
`endif
);

  localparam int unsigned EVT_W = $clog2(3 * NUM_CH + 1);
  localparam int unsigned SUM_W = ((ERR_CNT_W > EVT_W) ? ERR_CNT_W : EVT_W) + 1;

  logic                 w_cfg_bad;
  logic                 w_run;
  logic [NUM_CH-1:0]    w_early, w_tmo, w_proto;
  logic [NUM_CH-1:0]    r_ev_early, r_ev_tmo, r_ev_proto;
  logic [NUM_CH-1:0]    r_early, r_tmo, r_proto;
  logic [NUM_CH-1:0]    w_early_nxt, w_tmo_nxt, w_proto_nxt;
  logic [ERR_CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [EVT_W-1:0]     w_nevt;
  logic [SUM_W-1:0]     w_sum;
  logic                 r_cfg_err;
  logic                 r_irq;

  // Gate on both the live compare and its registered copy so that no
  // transaction opens while the window is invalid or just recovering.
  assign w_cfg_bad = (cfg_min_dly > cfg_max_dly);
  assign w_run     = enable & ~w_cfg_bad & ~r_cfg_err;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    err_evt_t w_evt;
`ifdef REQ_RSP_CHK_STAT_EN
    logic             w_pass;
    logic [CNT_W-1:0] w_lat;
    logic [CNT_W-1:0] r_max_lat;
`endif

    req_rsp_chan #(
      .CNT_W (CNT_W)
    ) u_chan (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_run     (w_run),
      .i_cfg_min (cfg_min_dly),
      .i_cfg_max (cfg_max_dly),
      .i_req     (req[g]),
      .i_rsp     (rsp[g]),
      .o_busy    (busy[g]),
      .o_evt     (w_evt)
`ifdef REQ_RSP_CHK_STAT_EN
      ,
      .o_pass    (w_pass),
      .o_lat     (w_lat)
`endif
    );

    assign w_early[g] = w_evt.early;
    assign w_tmo[g]   = w_evt.tmo;
    assign w_proto[g] = w_evt.proto;

`ifdef REQ_RSP_CHK_STAT_EN
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_max_lat <= '0;
      end else if (err_clr) begin
        r_max_lat <= '0;
      end else if (w_pass && (w_lat > r_max_lat)) begin
        r_max_lat <= w_lat;
      end
    end
    assign max_lat[g*CNT_W +: CNT_W] = r_max_lat;
`endif
  end

  // Events judged at one edge are registered first, then folded into the
  // sticky flags and counter on the following edge.
  always_comb begin
    w_nevt = EVT_W'($countones(r_ev_early)) + EVT_W'($countones(r_ev_tmo)) +
             EVT_W'($countones(r_ev_proto));
    if (err_clr) begin
      w_early_nxt = r_ev_early;
      w_tmo_nxt   = r_ev_tmo;
      w_proto_nxt = r_ev_proto;
      w_sum       = SUM_W'(w_nevt);
    end else begin
      w_early_nxt = r_early | r_ev_early;
      w_tmo_nxt   = r_tmo | r_ev_tmo;
      w_proto_nxt = r_proto | r_ev_proto;
      w_sum       = SUM_W'(r_cnt) + SUM_W'(w_nevt);
    end
    if (w_sum > SUM_W'({ERR_CNT_W{1'b1}})) begin
      w_cnt_nxt = '1;
    end else begin
      w_cnt_nxt = w_sum[ERR_CNT_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ev_early <= '0;
      r_ev_tmo   <= '0;
      r_ev_proto <= '0;
      r_early    <= '0;
      r_tmo      <= '0;
      r_proto    <= '0;
      r_cnt      <= '0;
      r_cfg_err  <= 1'b0;
      r_irq      <= 1'b0;
    end else begin
      r_ev_early <= w_early;
      r_ev_tmo   <= w_tmo;
      r_ev_proto <= w_proto;
      r_early    <= w_early_nxt;
      r_tmo      <= w_tmo_nxt;
      r_proto    <= w_proto_nxt;
      r_cnt      <= w_cnt_nxt;
      r_cfg_err  <= w_cfg_bad;
      r_irq      <= |{w_early_nxt, w_tmo_nxt, w_proto_nxt};
    end
  end

  assign err_early = r_early;
  assign err_tmo   = r_tmo;
  assign err_proto = r_proto;
  assign err_cnt   = r_cnt;
  assign cfg_err   = r_cfg_err;
  assign irq       = r_irq;

endmodule

// File: doc/req_rsp_checker.md
REQ_RSP_CHECKER -- requirements
Module: req_rsp_checker

Interface
REQ-001 Parameter NUM_CH, default 4, number of independent req/rsp channels (1..32).
REQ-002 Parameter CNT_W, default 8, latency counter and delay-config width.
REQ-003 Parameter ERR_CNT_W, default 16, global error counter width.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 enable  in  1  checking enable.
REQ-007 cfg_min_dly, cfg_max_dly  in  CNT_W each  allowed response latency window, inclusive.
REQ-008 req, rsp  in  NUM_CH each  per-channel request level and response pulse.
REQ-009 err_clr  in  1  clears sticky flags and err_cnt.
REQ-010 busy  out  NUM_CH  channel has an outstanding request.
REQ-011 err_early, err_tmo, err_proto  out  NUM_CH each  sticky per-channel error flags.
REQ-012 err_cnt  out  ERR_CNT_W  saturating total error count.
REQ-013 cfg_err  out  1  registered flag, high while cfg_min_dly > cfg_max_dly.
REQ-014 irq  out  1  registered OR of all sticky flags.

Function
REQ-015 Each channel SHALL run FSM IDLE/WAIT; a rise is req high at an edge with req low at the previous edge.
REQ-016 IDLE with rise -> WAIT, latency L=0, cfg_min/max captured into channel; later cfg changes SHALL NOT affect the open transaction.
REQ-017 L SHALL increment by 1 per edge in WAIT; rsp sampled at latency L is judged against the captured window.
REQ-018 rsp with L < min -> err_early, -> IDLE; min <= L <= max -> pass, -> IDLE, no flag.
REQ-019 No rsp by L = max -> err_tmo at L = max+1 edge, -> IDLE; captured max = all-ones disables timeout (L saturates at all-ones).
REQ-020 rsp in the rise cycle SHALL count as L=0 (pass only if min = 0).
REQ-021 rsp in IDLE without rise, or rise while in WAIT -> err_proto; a rise in WAIT SHALL NOT restart the transaction.
REQ-022 busy SHALL equal (state == WAIT).
REQ-023 Error flags SHALL set one cycle after the judging edge and stay set until err_clr.
REQ-024 err_cnt SHALL add the number of new error events of all channels in that cycle, saturating at all-ones.
REQ-025 err_clr with simultaneous new errors: new errors win -- flags set, err_cnt = count of those events.
REQ-026 enable low or cfg_err high: all channels forced to IDLE next edge, no errors raised; rise tracking continues, so a req already high on re-enable is not a rise.

Reset
REQ-027 rst_n low SHALL immediately force all FSMs IDLE, L=0, req history 0, and busy, all err flags, err_cnt, cfg_err, irq to 0.
REQ-028 Reset deassertion mid-transaction SHALL leave no residual state; first rise after reset is checked normally.

Configuration
REQ-029 Macro REQ_RSP_CHK_STAT_EN compiled in: add output max_lat (NUM_CH*CNT_W), per-channel maximum passing latency, cleared by reset and err_clr.
REQ-030 Without REQ_RSP_CHK_STAT_EN: max_lat port and its registers SHALL be absent; all other behaviour identical.

Structure
REQ-031 Package req_rsp_chk_pkg SHALL hold the channel-state enum, an error-event struct {early, tmo, proto}, and parameter defaults.
REQ-032 Per-channel FSM and latency counter SHALL be sub-module req_rsp_chan, instantiated NUM_CH times; top holds flags, counter, irq.

Verification
REQ-033 min=2,max=5; ch0 rise at cycle 10, rsp at L=3 -> no flag, busy high cycles 10-12, err_cnt=0.
REQ-034 min=2,max=5; ch1 rsp at L=1 -> err_early[1]=1, err_cnt=1, irq=1 next cycle.
REQ-035 min=2,max=5; ch2 no rsp -> err_tmo[2] at L=6, busy low after; max=255 (CNT_W=8) -> no timeout after 300 cycles.
REQ-036 ch0 and ch3 errors in the same cycle as err_clr -> both flags set, err_cnt=2.
REQ-037 rsp on idle ch1, and second rise on busy ch2 -> err_proto[1], err_proto[2]; ch2 passes on original timing.
REQ-038 rst_n low at L=3 of ch0, rsp after release -> err_proto[0]; min=6,max=3 -> cfg_err=1, no checks run.
